// File: rtl/pkt_fifo_reader_if.sv
// Byte stream toward the MAC TX framer: data, valid, last, ready.
interface pkt_fifo_reader_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/pkt_fifo_reader.sv
// Whole-packet reader for the 8-bit + EOD packet FIFO, with inter-frame gap.
// Optional stat_pkts/stat_bytes counters are built when PKT_FIFO_READER_STATS_EN is defined.
module pkt_fifo_reader #(
    parameter int IFG_CYCLES = 12,
    parameter int PKT_CNT_W  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_wr_done,
    output logic                 fifo_re,
    input  logic [7:0]           fifo_do,
    input  logic                 fifo_eod,
    input  logic                 fifo_empty,
    pkt_fifo_reader_if.master    tx,
    output logic                 busy,
    output logic [PKT_CNT_W-1:0] pkt_pending,
    output logic                 err_flag
`ifdef PKT_FIFO_READER_STATS_EN
    ,
    output logic [31:0]          stat_pkts,
    output logic [31:0]          stat_bytes
`endif
);

    localparam int DATA_W = 8;
    localparam int GAP_W  = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    state_t                state, state_nxt;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_nxt;
    logic                  eod_fetched, eod_fetched_nxt;
    logic                  rd_vld_p1;
    logic [DATA_W-1:0]     buf_data [2];
    logic [1:0]            buf_last;
    logic [1:0]            occ;
    logic                  pop;
    logic                  cap_eod;
    logic                  wr_idx;
    logic [2:0]            room_calc;
    logic                  underrun;
    logic [PKT_CNT_W:0]    pend_upd;

    // Saturating packet counter update; the top bit flags overflow or underflow.
    function automatic logic [PKT_CNT_W:0] pend_next(input logic [PKT_CNT_W-1:0] cnt,
                                                      input logic inc, input logic dec);
        logic [PKT_CNT_W-1:0] max_v;
        max_v = '1;
        case ({inc, dec})
            2'b10:   pend_next = (cnt == max_v) ? {1'b1, cnt} : {1'b0, cnt + PKT_CNT_W'(1)};
            2'b01:   pend_next = (cnt == '0)    ? {1'b1, cnt} : {1'b0, cnt - PKT_CNT_W'(1)};
            default: pend_next = {1'b0, cnt};
        endcase
    endfunction

    assign cap_eod    = rd_vld_p1 & fifo_eod;
    assign tx.m_valid = (occ != 2'd0);
    assign tx.m_data  = tx.m_valid ? buf_data[0] : '0;
    assign tx.m_last  = tx.m_valid & buf_last[0];
    assign pop        = tx.m_valid & tx.m_ready;
    assign wr_idx     = occ[1] | (occ[0] & ~pop);
    assign room_calc  = {1'b0, occ} + {2'b0, rd_vld_p1} - {2'b0, pop};
    assign busy       = (state != IDLE);
    assign pend_upd   = pend_next(pkt_pending, pkt_wr_done, cap_eod);

    // A byte captured this cycle with EOD already blocks the next read of the same packet.
    always_comb begin
        state_nxt       = state;
        gap_cnt_nxt     = gap_cnt;
        eod_fetched_nxt = eod_fetched | cap_eod;
        fifo_re         = 1'b0;
        underrun        = 1'b0;
        case (state)
            IDLE: begin
                eod_fetched_nxt = 1'b0;
                if ((pkt_pending != '0) && !fifo_empty) begin
                    fifo_re   = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                underrun = fifo_empty & ~eod_fetched_nxt;
                fifo_re  = ~fifo_empty & ~eod_fetched_nxt & (room_calc < 3'd2);
                if (pop && tx.m_last) begin
                    if (IFG_CYCLES == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_W'(IFG_CYCLES);
                    end
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt - GAP_W'(1);
                if (gap_cnt <= GAP_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p1: capture of the byte requested by last cycle's fifo_re
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gap_cnt     <= '0;
            eod_fetched <= 1'b0;
            rd_vld_p1   <= 1'b0;
            occ         <= 2'd0;
            pkt_pending <= '0;
            err_flag    <= 1'b0;
        end else begin
            state       <= state_nxt;
            gap_cnt     <= gap_cnt_nxt;
            eod_fetched <= eod_fetched_nxt;
            rd_vld_p1   <= fifo_re;
            occ         <= occ - {1'b0, pop} + {1'b0, rd_vld_p1};
            pkt_pending <= pend_upd[PKT_CNT_W-1:0];
            if (pend_upd[PKT_CNT_W] || underrun) begin
                err_flag <= 1'b1;
            end
        end
    end

    // Skid storage holds data only; emptiness is tracked by occ.
    always_ff @(posedge clk) begin
        if (pop) begin
            buf_data[0] <= buf_data[1];
            buf_last[0] <= buf_last[1];
        end
        if (rd_vld_p1) begin
            buf_data[wr_idx] <= fifo_do;
            buf_last[wr_idx] <= fifo_eod;
        end
    end

`ifdef PKT_FIFO_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
        end else begin
            if (pop) begin
                stat_bytes <= stat_bytes + 32'd1;
            end
            if (pop && tx.m_last) begin
                stat_pkts <= stat_pkts + 32'd1;
            end
        end
    end
`endif

endmodule
